md_unit: RTL and testbench

//   Multiply/divide unit in the EX stage, beside the ALU and fed by the same SrcA/SrcB operands.

---
 rtl/md_unit_if.sv | 14 +
 rtl/md_unit.sv | 106 ++++++++++
 tb/tb_md_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives operands and start; the unit returns HI/LO and busy.
interface md_unit_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  MDctrl;
  logic        start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  modport master (output SrcA, SrcB, MDctrl, start, input HI, LO, busy);
  modport slave  (input SrcA, SrcB, MDctrl, start, output HI, LO, busy);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO.
// The result is computed at accept time and released after a fixed latency.
module md_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic     clk,
  input  logic     reset_n,
  md_unit_if.slave md
);
  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   res_hi_q, res_lo_q;
  logic          keep_q;

  logic [31:0] a, b;
  logic        is_mul, is_div, is_signed, div0;
  logic [63:0] prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi_d, res_lo_d;

  assign a         = md.SrcA;
  assign b         = md.SrcB;
  assign is_mul    = (md.MDctrl == OP_MULT) || (md.MDctrl == OP_MULTU);
  assign is_div    = (md.MDctrl == OP_DIV)  || (md.MDctrl == OP_DIVU);
  assign is_signed = (md.MDctrl == OP_MULT) || (md.MDctrl == OP_DIV);
  assign div0      = (b == 32'd0);

  // Sign-extending to 64 bits makes one unsigned multiplier serve both forms.
  assign prod = {{32{is_signed & a[31]}}, a} * {{32{is_signed & b[31]}}, b};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend; 0x80000000 / -1 wraps naturally to 0x80000000.
  assign neg_a = is_signed & a[31];
  assign neg_b = is_signed & b[31];
  assign mag_a = neg_a ? (~a + 32'd1) : a;
  assign mag_b = neg_b ? (~b + 32'd1) : b;
  assign div_b = div0 ? 32'd1 : mag_b;
  assign q_mag = mag_a / div_b;
  assign r_mag = mag_a % div_b;
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  assign res_hi_d = is_mul ? prod[63:32] : rem;
  assign res_lo_d = is_mul ? prod[31:0]  : quo;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      keep_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.start) begin
            if (is_mul || is_div) begin
              state_q  <= RUN;
              cnt_q    <= is_mul ? CW'(MULT_LAT - 1) : CW'(DIV_LAT - 1);
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              keep_q   <= is_div && div0;
            end else if (md.MDctrl == OP_MTHI) begin
              hi_q <= a;
            end else if (md.MDctrl == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            if (!keep_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
  assign md.busy = (state_q == RUN);
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle-level reference model checked every cycle,
// plus literal expectations from hand arithmetic.
module tb_md_unit;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  md_unit_if mdi();

  md_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (.clk(clk), .reset_n(reset_n), .md(mdi.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: pending result released at an absolute cycle number.
  int          cyc = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic        m_busy = 0;
  bit          pend = 0, p_skip = 0;
  int          due = 0;
  logic [31:0] p_hi = 0, p_lo = 0;

  task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output bit skip);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0] w;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};           ub = {32'd0, b};
    skip = 0; hi = 0; lo = 0;
    case (op)
      3'd1: begin w = sa * sb; hi = w[63:32]; lo = w[31:0]; end
      3'd2: begin p = ua * ub; w = p; hi = w[63:32]; lo = w[31:0]; end
      3'd3: if (b == 0) skip = 1;
            else begin q = sa / sb; r = sa % sb; w = q; lo = w[31:0]; w = r; hi = w[31:0]; end
      3'd4: if (b == 0) skip = 1;
            else begin p = ua / ub; w = p; lo = w[31:0]; p = ua % ub; w = p; hi = w[31:0]; end
      default: skip = 1;
    endcase
  endtask

  always @(posedge clk) begin
    bit was_busy;
    cyc++;
    was_busy = pend;
    if (!reset_n) begin
      m_hi = 0; m_lo = 0; pend = 0;
    end else begin
      if (pend && cyc == due) begin
        if (!p_skip) begin m_hi = p_hi; m_lo = p_lo; end
        pend = 0;
      end
      if (!was_busy && mdi.start) begin
        if (mdi.MDctrl inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
          compute(mdi.MDctrl, mdi.SrcA, mdi.SrcB, p_hi, p_lo, p_skip);
          pend = 1;
          due  = cyc + ((mdi.MDctrl <= 3'd2) ? ML : DL);
        end else if (mdi.MDctrl == 3'd5) m_hi = mdi.SrcA;
        else if (mdi.MDctrl == 3'd6) m_lo = mdi.SrcA;
      end
    end
    m_busy = pend;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (mdi.HI !== m_hi || mdi.LO !== m_lo || mdi.busy !== m_busy) begin
        n_bad++;
        $display("FAIL model cyc=%0d: got HI=%h LO=%h busy=%b, want HI=%h LO=%h busy=%b",
                 cyc, mdi.HI, mdi.LO, mdi.busy, m_hi, m_lo, m_busy);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdi.start = 1'b1; mdi.MDctrl = op; mdi.SrcA = a; mdi.SrcB = b;
    @(negedge clk);
    mdi.start = 1'b0; mdi.MDctrl = 3'd0;
  endtask

  // Counts busy cycles sampled from the negedge after the accepting edge.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (mdi.busy === 1'b1 && n < 60) begin n++; @(negedge clk); end
    if (n >= 60) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: busy never cleared, got %0d cycles, want idle", name, n);
    end
  endtask

  initial begin
    int n;
    mdi.start = 1'b1; mdi.MDctrl = 3'd1; mdi.SrcA = 32'd2; mdi.SrcB = 32'd3;
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    mdi.start = 1'b0; mdi.MDctrl = 3'd0;
    reset_n = 1'b1;
    lit("reset HI", mdi.HI, 32'h0);
    lit("reset LO", mdi.LO, 32'h0);
    lit("reset busy", {31'd0, mdi.busy}, 32'h0);

    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    lit("mult HI old", mdi.HI, 32'h0);
    wait_idle("mult", n);
    lit("mult busy cycles", n, ML);
    lit("mult HI", mdi.HI, 32'hFFFFFFFF);
    lit("mult LO", mdi.LO, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle("multu", n);
    lit("multu HI", mdi.HI, 32'h00000002);
    lit("multu LO", mdi.LO, 32'hFFFFFFFA);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle("div", n);
    lit("div busy cycles", n, DL);
    lit("div LO", mdi.LO, 32'hFFFFFFFD);
    lit("div HI", mdi.HI, 32'hFFFFFFFF);

    issue(3'd4, 32'd7, 32'd2);
    wait_idle("divu", n);
    lit("divu LO", mdi.LO, 32'd3);
    lit("divu HI", mdi.HI, 32'd1);

    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd4, 32'd5, 32'd0);
    wait_idle("div0", n);
    lit("div0 busy cycles", n, DL);
    lit("div0 HI", mdi.HI, 32'h11);
    lit("div0 LO", mdi.LO, 32'h22);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div ovf", n);
    lit("div ovf LO", mdi.LO, 32'h80000000);
    lit("div ovf HI", mdi.HI, 32'h0);

    // MTHI attempted while the multiply is in flight must be dropped.
    issue(3'd1, 32'd3, 32'd4);
    mdi.start = 1'b1; mdi.MDctrl = 3'd5; mdi.SrcA = 32'hDEAD;
    @(negedge clk);
    mdi.start = 1'b0; mdi.MDctrl = 3'd0;
    wait_idle("mult ignore", n);
    lit("ignore HI", mdi.HI, 32'h0);
    lit("ignore LO", mdi.LO, 32'd12);

    issue(3'd6, 32'h1234, 32'd0);
    lit("mtlo LO", mdi.LO, 32'h1234);
    lit("mtlo busy", {31'd0, mdi.busy}, 32'h0);

    // Start held through the whole multiply: DIVU lands on the edge after busy falls.
    issue(3'd1, 32'd5, 32'd6);
    mdi.start = 1'b1; mdi.MDctrl = 3'd4; mdi.SrcA = 32'd9; mdi.SrcB = 32'd4;
    repeat (ML + 1) @(negedge clk);
    mdi.start = 1'b0; mdi.MDctrl = 3'd0;
    lit("b2b mult LO", mdi.LO, 32'd30);
    lit("b2b busy", {31'd0, mdi.busy}, 32'h1);
    wait_idle("b2b divu", n);
    lit("b2b divu LO", mdi.LO, 32'd2);
    lit("b2b divu HI", mdi.HI, 32'd1);

    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    lit("midreset busy", {31'd0, mdi.busy}, 32'h0);
    lit("midreset HI", mdi.HI, 32'h0);
    lit("midreset LO", mdi.LO, 32'h0);
    repeat (DL + 4) @(negedge clk);
    lit("midreset late HI", mdi.HI, 32'h0);
    lit("midreset late LO", mdi.LO, 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
